stream_pkt_arbiter: RTL
=======================

Name: stream_pkt_arbiter

Overview:
- Packet-level round-robin arbiter that shares one downstream stream datapath between NUM_PORTS requester streams, typically a width converter instance.
- Once a requester wins, its whole packet passes uninterrupted, through din_last, before re-arbitration.
- The output is a registered 2-entry skid stage, so the downstream path sees registered valid, data and last.
- dout_id tags every beat with its source port.

Parameters:
NUM_PORTS, 4, number of requester streams (>=1)
DATA_WIDTH, 32, beat width in bits (multiple of 8)
ID_WIDTH, 2, width of port index (>= clog2(NUM_PORTS), min 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cen  in  1  clock enable; when 0, no state or register updates and all din_ready are forced 0
din  in  NUM_PORTS*DATA_WIDTH  packed requester data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
din_strb  in  NUM_PORTS*DATA_WIDTH/8  packed byte strobes
din_last  in  NUM_PORTS  end-of-packet per port
din_valid  in  NUM_PORTS  beat valid per port
din_ready  out  NUM_PORTS  beat accept per port (at most one bit high)
dout  out  DATA_WIDTH  arbitrated data
dout_strb  out  DATA_WIDTH/8  arbitrated strobes
dout_last  out  1  end-of-packet
dout_id  out  ID_WIDTH  source port of current beat
dout_valid  out  1  output beat valid
dout_ready  in  1  downstream accept
grant_active  out  1  a packet grant is held
grant_id  out  ID_WIDTH  currently or last granted port

Behaviour:
- Parameter violation (DATA_WIDTH%8!=0, NUM_PORTS<1, ID_WIDTH too small) is an elaboration error.
- Reset values:
  - Outputs: dout_valid=0, dout=0, dout_strb=0, dout_last=0, dout_id=0, din_ready=0, grant_active=0, grant_id=0.
  - State: FSM=IDLE, rr pointer=0, skid empty.
- Transfers occur only on clock edges with cen=1: input beat when din_valid[k]&din_ready[k]; output beat when dout_valid&dout_ready.
- FSM states:
  - IDLE: if any din_valid, the winner is the first port with din_valid=1 searching from ptr upward, wrapping N-1->0. Next cycle: BUSY, grant_active=1, grant_id=winner. If no valid, stay IDLE.
  - BUSY: din_ready[grant_id]=~skid_full (registered); all other din_ready=0. An accepted beat with din_last=1 -> IDLE, grant_active=0, ptr=(grant_id+1) mod NUM_PORTS. grant_id holds its value in IDLE.
- Grant latency: 1 idle cycle between grant decision and first din_ready. Minimum inter-packet gap is 1 cycle, so one single-beat packet per 2 cycles is the peak rate for 1-beat packets.
- No preemption: the granted port dropping din_valid mid-packet holds the grant indefinitely. Other ports wait.
- Skid stage:
  - Input-accept to dout_valid latency is 1 cycle.
  - Full throughput of 1 beat/cycle within a packet under continuous dout_ready.
  - dout_ready low: at most one extra beat is captured, then din_ready drops next cycle.
  - Beat order is preserved.
  - dout/strb/last/id are stable while dout_valid=1 and dout_ready=0.
- dout_id equals the grant_id captured with the beat, not the live grant.
- Zero-strobe beats pass unchanged; the arbiter never inspects strobes.
- Reset asserted mid-packet: the packet is truncated. Skid contents are discarded, dout_valid=0 the next cycle, and ptr returns to 0. No last is synthesised.
- NUM_PORTS=1: arbitration is trivial, and the 1-cycle gap after each last still applies.
- cen=0 for any duration: outputs hold, nothing is accepted, and resuming with cen=1 continues exactly where it stopped.

Test Plan:
- Reset, then ports 0-3 all valid with 3-beat packets and dout_ready=1 -> packets emerge in id order 0,1,2,3,0. Each packet is 3 contiguous dout beats with last on the 3rd, and there is a 1-cycle gap between packets.
- Only port 2 valid, single-beat packet data=0xA5A5A5A5 at cycle t (ptr=0) -> din_ready[2] at t+1; dout=0xA5A5A5A5, dout_id=2, dout_last=1, dout_valid at t+2; ptr becomes 3.
- Port 1 granted, 8-beat packet, dout_ready toggled 1,0,0,1,... -> all 8 beats delivered in order with no loss or duplication, and dout stable while stalled.
- Port 0 granted, deasserts din_valid after beat 2 for 5 cycles while port 3 is valid -> port 3 is not granted until port 0's last beat is accepted.
- rst pulsed during beat 4 of a 6-beat packet -> next cycle dout_valid=0, grant_active=0, all din_ready=0; the first post-reset grant goes to the lowest valid port.
- cen held low for 4 cycles mid-packet with dout_valid=1 -> no din_ready, outputs unchanged; the packet completes correctly after cen returns high.

Source files
------------

// File: rtl/stream_pkt_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS requester streams share one downstream stream.
// A granted port keeps the datapath until its last beat; output is a registered 2-entry skid.
module stream_pkt_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cen_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   din_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] din_strb_i,
  input  logic [NUM_PORTS-1:0]              din_last_i,
  input  logic [NUM_PORTS-1:0]              din_valid_i,
  output logic [NUM_PORTS-1:0]              din_ready_o,
  output logic [DATA_WIDTH-1:0]             dout_o,
  output logic [DATA_WIDTH/8-1:0]           dout_strb_o,
  output logic                              dout_last_o,
  output logic [ID_WIDTH-1:0]               dout_id_o,
  output logic                              dout_valid_o,
  input  logic                              dout_ready_i,
  output logic                              grant_active_o,
  output logic [ID_WIDTH-1:0]               grant_id_o
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned BeatW     = DATA_WIDTH + StrbWidth + 1 + ID_WIDTH;
  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;
  localparam logic [ID_WIDTH-1:0] LastPort = ID_WIDTH'(NUM_PORTS - 1);

  if (NUM_PORTS < 1 || DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0 || ID_WIDTH < 1 ||
      (NUM_PORTS > 1 && ID_WIDTH < $clog2(NUM_PORTS))) begin : gen_param_err
    $error("stream_pkt_arbiter: illegal parameter combination");
  end

  logic                 state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]  grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]  winner;
  logic                 found;
  logic [NUM_PORTS-1:0] din_ready_q, din_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [BeatW-1:0]     out_q, out_d;
  logic [BeatW-1:0]     skid_q, skid_d;
  logic [BeatW-1:0]     in_beat;
  logic                 sel_last;
  logic                 in_fire;
  logic                 out_fire;

  assign din_ready_o = {NUM_PORTS{cen_i}} & din_ready_q;
  assign in_fire     = |(din_valid_i & din_ready_o);
  assign out_fire    = cen_i & out_valid_q & dout_ready_i;

  // The beat carries the grant it was accepted under, so dout_id never follows a later grant.
  always_comb begin
    in_beat  = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant_id_q == ID_WIDTH'(k)) begin
        sel_last = din_last_i[k];
        in_beat  = {din_i[k*DATA_WIDTH +: DATA_WIDTH], din_strb_i[k*StrbWidth +: StrbWidth],
                    din_last_i[k], grant_id_q};
      end
    end
  end

  // First pass covers ports at or above the pointer, second pass wraps to the low ports.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && din_valid_i[k] && k >= int'(ptr_q)) begin
        found  = 1'b1;
        winner = ID_WIDTH'(k);
      end
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && din_valid_i[k]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StBusy;
          grant_id_d = winner;
        end
      end
      StBusy: begin
        if (in_fire && sel_last) begin
          state_d = StIdle;
          ptr_d   = (grant_id_q == LastPort) ? '0 : ID_WIDTH'(grant_id_q + 1'b1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_fire || !out_valid_q) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) skid_d = in_beat;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = in_beat;
      end
    end else if (in_fire) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  // Ready is registered from next state, so a full skid blocks the following cycle.
  always_comb begin
    din_ready_d = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      din_ready_d[k] = (state_d == StBusy) && !skid_valid_d && (grant_id_d == ID_WIDTH'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      grant_id_q   <= '0;
      din_ready_q  <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (cen_i) begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_id_q   <= grant_id_d;
      din_ready_q  <= din_ready_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign dout_o         = out_q[BeatW-1 -: DATA_WIDTH];
  assign dout_strb_o    = out_q[ID_WIDTH+1 +: StrbWidth];
  assign dout_last_o    = out_q[ID_WIDTH];
  assign dout_id_o      = out_q[ID_WIDTH-1:0];
  assign dout_valid_o   = out_valid_q;
  assign grant_active_o = (state_q == StBusy);
  assign grant_id_o     = grant_id_q;

endmodule
